// File: rtl/pg_prefix_sum_pipe_if.sv
// rtl/pg_prefix_sum_pipe_if.sv - handshake bundle for the pipelined prefix-sum carry network
// Signals:
//   in_valid/in_ready   operation handshake, in_pg = {p,g} pairs per bit, in_cin = carry-in
//   out_valid/out_ready result handshake, out_sum = sum bits, out_cout = carry-out
// Modports: master = producer/consumer side, slave = the pipeline.
interface pg_prefix_sum_pipe_if #(
  parameter int WIDTH = 16
);
  logic               in_valid;
  logic               in_ready;
  logic [2*WIDTH-1:0] in_pg;
  logic               in_cin;
  logic               out_valid;
  logic               out_ready;
  logic [WIDTH-1:0]   out_sum;
  logic               out_cout;

  modport master (
    output in_valid, in_pg, in_cin, out_ready,
    input  in_ready, out_valid, out_sum, out_cout
  );

  modport slave (
    input  in_valid, in_pg, in_cin, out_ready,
    output in_ready, out_valid, out_sum, out_cout
  );
endinterface

// File: rtl/pg_prefix_sum_pipe.sv
// rtl/pg_prefix_sum_pipe.sv - pipelined Kogge-Stone carry network and sum stage
// Ports:
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset (clears valid bits, discards in-flight ops)
//   bus    slave side of pg_prefix_sum_pipe_if (in_* operation, out_* result)
// Stage 0 captures p/g with cin folded into g[0]; stages 1..LOG2W each register
// one prefix level. The sum is formed combinationally from the last stage, so a
// result appears LOG2W+1 cycles after accept. A single global advance stalls the
// whole pipe when the result is not taken.
module pg_prefix_sum_pipe #(
  parameter int WIDTH = 16,
  parameter int LOG2W = 4
) (
  input logic                 clk,
  input logic                 rst_n,
  pg_prefix_sum_pipe_if.slave bus
);

  logic             advance;
  logic [LOG2W:0]   v_r;

  assign advance      = ~v_r[LOG2W] | bus.out_ready;
  assign bus.in_ready = advance;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v_r <= '0;
    end else if (advance) begin
      v_r <= {v_r[LOG2W-1:0], bus.in_valid};
    end
  end

  for (genvar k = 0; k <= LOG2W; k++) begin : st
    // p_q: raw propagate for the sum, g_q: prefix generate, cin_q: op carry-in
    logic [WIDTH-1:0] p_d, g_d, p_q, g_q;
    logic             cin_d, cin_q;

    // Group propagate is only needed to feed a later level, so the last
    // stage does not keep it.
    if (k < LOG2W) begin : pq
      logic [WIDTH-1:0] pp_d, pp_q;

      if (k == 0) begin : c0
        assign pp_d = p_d;
      end else begin : cn
        localparam int D = 1 << (k - 1);
        always_comb begin
          pp_d = st[k-1].pq.pp_q;
          for (int i = D; i < WIDTH; i++) begin
            pp_d[i] = st[k-1].pq.pp_q[i] & st[k-1].pq.pp_q[i-D];
          end
        end
      end

      always_ff @(posedge clk) begin
        if (advance) begin
          pp_q <= pp_d;
        end
      end
    end

    if (k == 0) begin : cap
      always_comb begin
        p_d   = '0;
        g_d   = '0;
        cin_d = bus.in_cin;
        for (int i = 0; i < WIDTH; i++) begin
          p_d[i] = bus.in_pg[2*i+1];
          g_d[i] = bus.in_pg[2*i];
        end
        // Carry-in behaves like a generate into bit 0.
        g_d[0] = g_d[0] | (p_d[0] & bus.in_cin);
      end
    end else begin : lvl
      localparam int D = 1 << (k - 1);
      always_comb begin
        p_d   = st[k-1].p_q;
        cin_d = st[k-1].cin_q;
        g_d   = st[k-1].g_q;
        for (int i = D; i < WIDTH; i++) begin
          g_d[i] = st[k-1].g_q[i] | (st[k-1].pq.pp_q[i] & st[k-1].g_q[i-D]);
        end
      end
    end

    always_ff @(posedge clk) begin
      if (advance) begin
        p_q   <= p_d;
        g_q   <= g_d;
        cin_q <= cin_d;
      end
    end
  end

  // After the last level g_q[i] is the carry out of bit i.
  logic [WIDTH-1:0] carry;
  assign carry = {st[LOG2W].g_q[WIDTH-2:0], st[LOG2W].cin_q};

  // Masking with the valid bit gives zero outputs in reset without resetting data.
  assign bus.out_valid = v_r[LOG2W];
  assign bus.out_sum   = v_r[LOG2W] ? (st[LOG2W].p_q ^ carry) : '0;
  assign bus.out_cout  = v_r[LOG2W] & st[LOG2W].g_q[WIDTH-1];

endmodule

// File: tb/tb_pg_prefix_sum_pipe.sv
// tb/tb_pg_prefix_sum_pipe.sv - scoreboard bench for pg_prefix_sum_pipe
module tb_pg_prefix_sum_pipe;
  localparam int W = 16;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  pg_prefix_sum_pipe_if #(.WIDTH(W)) bus ();
  pg_prefix_sum_pipe #(.WIDTH(W), .LOG2W(4)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  int total = 0;
  int bad = 0;
  logic [W:0] exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, req);
    end
  endtask

  function automatic logic [2*W-1:0] mk_pg(input logic [W-1:0] a, input logic [W-1:0] b);
    logic [2*W-1:0] pg;
    for (int i = 0; i < W; i++) begin
      pg[2*i+1] = a[i] ^ b[i];
      pg[2*i]   = a[i] & b[i];
    end
    return pg;
  endfunction

  // monitor: a result is consumed at the next posedge when valid & ready
  initial begin : mon
    logic [W:0] e;
    forever begin
      @(negedge clk);
      #1;
      if (rst_n && bus.out_valid && bus.out_ready) begin
        if (exp_q.size() == 0) begin
          check("unexpected_out", {15'd0, bus.out_cout, bus.out_sum}, 32'hDEAD);
        end else begin
          e = exp_q.pop_front();
          check("result", {15'd0, bus.out_cout, bus.out_sum}, {15'd0, e});
        end
      end
    end
  end

  task automatic send(input logic [W-1:0] a, input logic [W-1:0] b, input logic cin);
    int n = 0;
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.in_pg    = mk_pg(a, b);
    bus.in_cin   = cin;
    #1;
    while (!bus.in_ready && n < 50) begin
      @(negedge clk);
      #1;
      n++;
    end
    if (!bus.in_ready) check("send_timeout", 0, 1);
    else exp_q.push_back({1'b0, a} + {1'b0, b} + {16'd0, cin});
  endtask

  // negedges until out_valid is seen, input idle meanwhile
  task automatic wait_valid(output int cyc);
    cyc = 0;
    do begin
      @(negedge clk);
      bus.in_valid = 1'b0;
      #1;
      cyc++;
    end while (!bus.out_valid && cyc < 20);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      bus.in_valid = 1'b0;
    end
  endtask

  initial begin : drv
    int cyc;
    int n;
    logic [W:0] held;
    logic pend;
    logic [W-1:0] ra, rb;
    logic rc;

    bus.in_valid = 1'b0;
    bus.in_pg = '0;
    bus.in_cin = 1'b0;
    bus.out_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check("rst_out_valid", bus.out_valid, 0);
    check("rst_out_sum", bus.out_sum, 0);
    check("rst_out_cout", bus.out_cout, 0);
    rst_n = 1'b1;
    #1;
    check("rst_in_ready", bus.in_ready, 1);

    // 1: basic add and latency
    send(16'h1234, 16'h4321, 1'b0);
    wait_valid(cyc);
    check("latency", cyc, 5);
    idle(3);

    // 2, 3: full carry ripple and carry-in
    send(16'hFFFF, 16'h0001, 1'b0);
    send(16'hFFFF, 16'h0000, 1'b1);
    send(16'hFFFF, 16'h0000, 1'b0);
    idle(8);

    // 4: back-to-back
    send(16'h0001, 16'h0002, 1'b0);
    send(16'h8000, 16'h8000, 1'b0);
    send(16'h7FFF, 16'h0000, 1'b1);
    send(16'hAAAA, 16'h5555, 1'b1);
    send(16'h0F0F, 16'hF0F0, 1'b0);
    wait_valid(cyc);
    check("b2b_first", cyc, 1);
    for (int j = 0; j < 4; j++) begin
      @(negedge clk);
      #1;
      check("b2b_consecutive", bus.out_valid, 1);
    end
    idle(6);

    // 5: stall with full pipe
    send(16'h1111, 16'h0001, 1'b0);
    send(16'h2222, 16'h0002, 1'b0);
    send(16'h3333, 16'h0003, 1'b1);
    send(16'h4444, 16'h0004, 1'b0);
    send(16'h5555, 16'h0005, 1'b1);
    @(negedge clk);
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b0;
    #1;
    held = {bus.out_cout, bus.out_sum};
    check("stall_held_value", {15'd0, held}, {15'd0, 17'h01112});
    for (int j = 0; j < 3; j++) begin
      if (j > 0) begin
        @(negedge clk);
        #1;
      end
      check("stall_in_ready", bus.in_ready, 0);
      check("stall_out_valid", bus.out_valid, 1);
      check("stall_out_hold", {15'd0, bus.out_cout, bus.out_sum}, {15'd0, held});
    end
    @(negedge clk);
    bus.out_ready = 1'b1;
    idle(8);
    check("stall_drained", exp_q.size(), 0);

    // 6: reset with ops in flight
    bus.out_ready = 1'b0;
    send(16'h0101, 16'h0101, 1'b0);
    send(16'h0202, 16'h0202, 1'b0);
    send(16'h0303, 16'h0303, 1'b0);
    send(16'h0404, 16'h0404, 1'b0);
    send(16'h0505, 16'h0505, 1'b0);
    @(negedge clk);
    bus.in_valid = 1'b0;
    #1;
    check("pre_reset_valid", bus.out_valid, 1);
    #1;
    rst_n = 1'b0;
    #1;
    check("mid_reset_valid", bus.out_valid, 0);
    check("mid_reset_sum", bus.out_sum, 0);
    check("mid_reset_cout", bus.out_cout, 0);
    exp_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("post_reset_in_ready", bus.in_ready, 1);
    bus.out_ready = 1'b1;
    idle(8);
    send(16'h00FF, 16'h0001, 1'b1);
    wait_valid(cyc);
    check("post_reset_latency", cyc, 5);
    idle(3);

    // random traffic with random backpressure
    pend = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      bus.out_ready = ($urandom_range(0, 3) != 0);
      if (!pend) begin
        bus.in_valid = 1'b0;
        if ($urandom_range(0, 3) != 0) begin
          ra = W'($urandom);
          rb = W'($urandom);
          rc = 1'($urandom_range(0, 1));
          bus.in_pg = mk_pg(ra, rb);
          bus.in_cin = rc;
          bus.in_valid = 1'b1;
          pend = 1'b1;
        end
      end
      #1;
      if (pend && bus.in_ready) begin
        exp_q.push_back({1'b0, ra} + {1'b0, rb} + {16'd0, rc});
        pend = 1'b0;
      end
    end
    @(negedge clk);
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;
    n = 0;
    while (exp_q.size() != 0 && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("final_drain", exp_q.size(), 0);
    idle(2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
